tone_decoder: RTL
=================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter WINDOW_CYCLES, default 500_000, gives the measurement window length in clk cycles (10 ms at 50 MHz).
REQ-002 Parameter EDGE_MIN, default 5, gives the minimum rising edges per window for a channel to count as present.
REQ-003 Parameter EDGE_MAX, default 40, gives the maximum rising edges per window for a channel to count as present.
REQ-004 Parameter CONFIRM_WINDOWS, default 3, range >= 2, gives the consecutive identical windows required before a direction is issued.
REQ-005 clk  in  1  single system clock, 50 MHz; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 bp1..bp5  in  1 each  asynchronous band-pass comparator outputs; bp1..bp4 are the direction tones, bp5 is the broadband guard.
REQ-008 tdAck  in  1  single-cycle consumer acknowledge from the drive state machine.
REQ-009 tdEn  out  1  high while a confirmed direction is held.
REQ-010 tdDir  out  2  confirmed direction: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK.
REQ-011 tdPresent  out  5  per-channel presence result from the last completed window (bit0 = bp1).

Function
REQ-012 Each bp input SHALL pass through a 2-FF synchronizer; a rising edge is synced(n)=1 and synced(n-1)=0.
REQ-013 The window counter SHALL count 0..WINDOW_CYCLES-1 and wrap; winEnd is asserted for one cycle at count WINDOW_CYCLES-1.
REQ-014 Each channel SHALL have an 8-bit edge counter that increments per rising edge and saturates at 255.
REQ-015 On winEnd, edge counters SHALL reload: to 1 if an edge occurs that same cycle, otherwise to 0.
REQ-016 On winEnd, the block SHALL compute present[i] = (EDGE_MIN <= count[i] <= EDGE_MAX), where count[i] excludes any edge in the winEnd cycle, and register it to tdPresent.
REQ-017 A candidate window SHALL be one where exactly one of present[0..3] is set and present[4]=0; the candidate index is the set bit's position.
REQ-018 The FSM SHALL have four states: IDLE, CONFIRM, VALID, REARM. It evaluates only on winEnd, except VALID, which also responds to tdAck on any cycle.
REQ-019 IDLE: on a candidate window -> CONFIRM, cand<=index, confCnt<=1; otherwise stay in IDLE.
REQ-020 CONFIRM: on the same candidate, confCnt+1. When confCnt+1 = CONFIRM_WINDOWS -> VALID, tdDir<=cand, tdEn<=1.
REQ-021 CONFIRM: a different candidate restarts with cand<=new index, confCnt<=1; a non-candidate window -> IDLE.
REQ-022 tdEn SHALL rise on the cycle after the winEnd that completes confirmation; tdDir SHALL be valid in that same cycle.
REQ-023 VALID: tdEn=1 and tdDir held stable regardless of tone inputs. On tdAck=1 -> REARM, with tdEn=0 on the next cycle.
REQ-024 REARM: -> IDLE on a winEnd with tdPresent all zero; otherwise stay in REARM. tdDir keeps its last value.
REQ-025 tdAck outside VALID SHALL be ignored.
REQ-026 If tdAck and winEnd coincide in VALID, tdAck takes priority; that window's result only updates tdPresent.

Reset
REQ-027 With rst_n=0 at a clk edge, the following SHALL clear: synchronizers, window counter, edge counters, confCnt, cand, tdPresent=00000, tdEn=0, tdDir=00, state=IDLE.
REQ-028 Reset mid-window or mid-CONFIRM SHALL discard partial counts; the first full window starts at counter 0 on the cycle after rst_n returns high.

Verification (bench: WINDOW_CYCLES=1000, EDGE_MIN=4, EDGE_MAX=12, CONFIRM_WINDOWS=3)
REQ-029 bp2 with 8 edges/window for 3 windows -> tdPresent=00010 each window; tdEn=1, tdDir=01 one cycle after the 3rd winEnd.
REQ-030 bp1 and bp3 each with 8 edges/window -> tdPresent=00101 and tdEn stays 0; bp3 plus bp5 at 8 edges -> tdEn stays 0.
REQ-031 bp4 at 20 edges/window for 5 windows -> no detect; bp4 at exactly 12 edges/window for 3 windows -> tdEn=1, tdDir=11; at exactly 4 edges/window -> also detects.
REQ-032 bp3 for 2 windows then bp2 for 3 windows -> tdDir=01 issued after the 5th window, not the 3rd.
REQ-033 In VALID, pulse tdAck with tone continuing -> tdEn=0 next cycle, no reissue. After 1 silent window and 3 tone windows -> tdEn=1 again.
REQ-034 rst_n low for 1 cycle after 2 confirming windows -> outputs cleared; tdEn needs 3 further full windows.

Source files
------------

// File: rtl/tone_decoder_if.sv
// Decoder-to-drive-FSM handshake: confirmed direction, per-channel presence and the consumer acknowledge.
interface tone_decoder_if;
   logic       tdAck;
   logic       tdEn;
   logic [1:0] tdDir;
   logic [4:0] tdPresent;

   modport master (input tdAck, output tdEn, output tdDir, output tdPresent);
   modport slave  (output tdAck, input tdEn, input tdDir, input tdPresent);
endinterface

// File: rtl/tone_decoder.sv
// Tone direction decoder: counts comparator edges per window, qualifies a single direction tone
// over consecutive windows and holds the confirmed direction until the drive FSM acknowledges it.
module tone_decoder #(
   parameter int unsigned WINDOW_CYCLES   = 500_000,
   parameter int unsigned EDGE_MIN        = 5,
   parameter int unsigned EDGE_MAX        = 40,
   parameter int unsigned CONFIRM_WINDOWS = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           bp1,
   input  logic           bp2,
   input  logic           bp3,
   input  logic           bp4,
   input  logic           bp5,
   tone_decoder_if.master td
);

   localparam int unsigned NCH    = 5;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned CONF_W = $clog2(CONFIRM_WINDOWS + 1);

   typedef enum logic [1:0] {IDLE, CONFIRM, VALID, REARM} state_t;

   logic [NCH-1:0]   bp_raw;
   logic [NCH-1:0]   sync1, sync2, sync3;
   logic [NCH-1:0]   rise_c;
   logic [WIN_W-1:0] win_cnt;
   logic             win_end_c;
   logic [CNT_W-1:0] edge_cnt [NCH];
   logic [NCH-1:0]   present_c;
   logic             cand_hit_c;
   logic [1:0]       idx_c;
   logic             conf_last_c;

   state_t           state, state_nxt;
   logic [1:0]       cand, cand_nxt;
   logic [CONF_W-1:0] conf_cnt, conf_nxt;
   logic             en_nxt;
   logic [1:0]       dir_nxt;

   assign bp_raw = {bp5, bp4, bp3, bp2, bp1};

   // Two-flop synchronizer plus one history stage for rising-edge detection
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= bp_raw;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise_c    = sync2 & ~sync3;
   assign win_end_c = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)         win_cnt <= '0;
      else if (win_end_c) win_cnt <= '0;
      else                win_cnt <= win_cnt + 1'b1;
   end

   // An edge landing on the window boundary belongs to the next window
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) edge_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (win_end_c)
               edge_cnt[i] <= CNT_W'(rise_c[i]);
            else if (rise_c[i] && (edge_cnt[i] != {CNT_W{1'b1}}))
               edge_cnt[i] <= edge_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      present_c = '0;
      for (int i = 0; i < NCH; i++)
         present_c[i] = (32'(edge_cnt[i]) >= EDGE_MIN) && (32'(edge_cnt[i]) <= EDGE_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)         td.tdPresent <= '0;
      else if (win_end_c) td.tdPresent <= present_c;
   end

   // Exactly one direction tone and no broadband guard tone
   always_comb begin
      idx_c = 2'd0;
      case (present_c[3:0])
         4'b0010: idx_c = 2'd1;
         4'b0100: idx_c = 2'd2;
         4'b1000: idx_c = 2'd3;
         default: idx_c = 2'd0;
      endcase
   end

   assign cand_hit_c  = !present_c[4] && $onehot(present_c[3:0]);
   assign conf_last_c = ((32'(conf_cnt) + 32'd1) == CONFIRM_WINDOWS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= '0;
         conf_cnt  <= '0;
         td.tdEn   <= 1'b0;
         td.tdDir  <= '0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         conf_cnt  <= conf_nxt;
         td.tdEn   <= en_nxt;
         td.tdDir  <= dir_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (win_end_c && cand_hit_c) state_nxt = CONFIRM;
         CONFIRM: begin
            if (win_end_c) begin
               if (!cand_hit_c)                      state_nxt = IDLE;
               else if (idx_c == cand && conf_last_c) state_nxt = VALID;
            end
         end
         VALID:   if (td.tdAck) state_nxt = REARM;
         REARM:   if (win_end_c && (present_c == '0)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Acknowledge in VALID wins over a coinciding window end
   always_comb begin
      cand_nxt = cand;
      conf_nxt = conf_cnt;
      en_nxt   = td.tdEn;
      dir_nxt  = td.tdDir;
      unique case (state)
         IDLE: begin
            if (win_end_c && cand_hit_c) begin
               cand_nxt = idx_c;
               conf_nxt = CONF_W'(1);
            end
         end
         CONFIRM: begin
            if (win_end_c) begin
               if (!cand_hit_c) begin
                  conf_nxt = '0;
               end else if (idx_c == cand) begin
                  conf_nxt = conf_cnt + 1'b1;
                  if (conf_last_c) begin
                     en_nxt  = 1'b1;
                     dir_nxt = cand;
                  end
               end else begin
                  cand_nxt = idx_c;
                  conf_nxt = CONF_W'(1);
               end
            end
         end
         VALID:   if (td.tdAck) en_nxt = 1'b0;
         REARM:   en_nxt = 1'b0;
         default: en_nxt = 1'b0;
      endcase
   end

endmodule
